// File: rtl/ixu_sc_issue_queue.sv
// Age-ordered collapsing issue queue for the IXU single-cycle pipe.
// Selects the oldest micro-op whose sources are ready, including same-cycle wakeups.
module ixu_sc_issue_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       core_clock_i,
    input  logic                       core_reset_ni,
    input  logic                       core_flush_i,
    input  logic [17:0]                enq_data_i,
    input  logic                       enq_rs1_rdy_i,
    input  logic                       enq_rs2_rdy_i,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [5:0]                 wk0_dest_i,
    input  logic                       wk0_valid_i,
    input  logic [5:0]                 wk1_dest_i,
    input  logic                       wk1_valid_i,
    input  logic [5:0]                 wk2_dest_i,
    input  logic                       wk2_valid_i,
    output logic [17:0]                issue_data_o,
    output logic                       issue_valid_o,
    output logic [$clog2(DEPTH):0]     occupancy_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [CW-1:0] count_q, count_d;
    logic [5:0]    rob_q [DEPTH];
    logic [5:0]    rs1_q [DEPTH];
    logic [5:0]    rs2_q [DEPTH];
    logic          r1_q  [DEPTH];
    logic          r2_q  [DEPTH];
    logic [5:0]    rob_d [DEPTH];
    logic [5:0]    rs1_d [DEPTH];
    logic [5:0]    rs2_d [DEPTH];
    logic          r1_d  [DEPTH];
    logic          r2_d  [DEPTH];

    logic          vld   [DEPTH];
    logic          eff1  [DEPTH];
    logic          eff2  [DEPTH];
    logic          found;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] wr_idx;
    logic          issue_fire;
    logic          enq_fire;

    // Tag 0 is the hardwired zero register and never waits on a producer.
    function automatic logic src_ready(input logic [5:0] tag);
        return (tag == 6'd0)
            || (wk0_valid_i && (wk0_dest_i == tag))
            || (wk1_valid_i && (wk1_dest_i == tag))
            || (wk2_valid_i && (wk2_dest_i == tag));
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            vld[i]  = (CW'(i) < count_q);
            eff1[i] = r1_q[i] | src_ready(rs1_q[i]);
            eff2[i] = r2_q[i] | src_ready(rs2_q[i]);
        end
    end

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld[i] && eff1[i] && eff2[i]) begin
                found   = 1'b1;
                sel_idx = IW'(i);
            end
        end
    end

    assign issue_fire    = found && !core_flush_i;
    assign issue_valid_o = issue_fire;
    assign issue_data_o  = {rs2_q[sel_idx], rs1_q[sel_idx], rob_q[sel_idx]};
    assign enq_ready_o   = (count_q < CW'(DEPTH));
    assign occupancy_o   = count_q;
    assign enq_fire      = enq_valid_i && enq_ready_o && !core_flush_i;
    assign wr_idx        = IW'(count_q - CW'(issue_fire));

    // Entries above the issued slot move down one place, carrying captured wakeups.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int src;
            src = i;
            if (issue_fire && (i >= int'(sel_idx)) && (i < DEPTH - 1)) begin
                src = i + 1;
            end
            rob_d[i] = rob_q[IW'(src)];
            rs1_d[i] = rs1_q[IW'(src)];
            rs2_d[i] = rs2_q[IW'(src)];
            r1_d[i]  = eff1[IW'(src)];
            r2_d[i]  = eff2[IW'(src)];
        end
        if (enq_fire) begin
            rob_d[wr_idx] = enq_data_i[5:0];
            rs1_d[wr_idx] = enq_data_i[11:6];
            rs2_d[wr_idx] = enq_data_i[17:12];
            r1_d[wr_idx]  = enq_rs1_rdy_i | src_ready(enq_data_i[11:6]);
            r2_d[wr_idx]  = enq_rs2_rdy_i | src_ready(enq_data_i[17:12]);
        end
    end

    always_comb begin
        if (core_flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(enq_fire) - CW'(issue_fire);
        end
    end

    always_ff @(posedge core_clock_i) begin
        if (!core_reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: slots at or above count_q are never observed.
    always_ff @(posedge core_clock_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            rob_q[i] <= rob_d[i];
            rs1_q[i] <= rs1_d[i];
            rs2_q[i] <= rs2_d[i];
            r1_q[i]  <= r1_d[i];
            r2_q[i]  <= r2_d[i];
        end
    end

endmodule

// File: doc/ixu_sc_issue_queue.md
Name: ixu_sc_issue_queue

Overview:
- Age-ordered, collapsing issue queue feeding the IXU single-cycle ALU/branch pipe.
- Holds renamed micro-ops as a ROB id plus two physical source tags.
- Tracks source readiness from the wakeup buses and issues at most one ready micro-op per cycle.
- Issue payload is the 18-bit {rs2, rs1, rob} word with its valid strobe, consumed directly by the single-cycle pipe.

Parameters:
- DEPTH, 8, number of queue entries (power of two, 4..16).

Ports:
- core_clock_i  in  1  core clock
- core_reset_ni  in  1  reset; synchronous, active-low
- core_flush_i  in  1  pipeline flush; discards all entries
- enq_data_i  in  18  [5:0] ROB id, [11:6] rs1 tag, [17:12] rs2 tag
- enq_rs1_rdy_i  in  1  rs1 already ready at rename
- enq_rs2_rdy_i  in  1  rs2 already ready at rename
- enq_valid_i  in  1  enqueue request
- enq_ready_o  out  1  queue can accept (occupancy < DEPTH)
- wk0_dest_i  in  6  wakeup tag, this pipe (combinational, same cycle as issue)
- wk0_valid_i  in  1  wakeup 0 valid
- wk1_dest_i  in  6  wakeup tag, multi-cycle/load pipe
- wk1_valid_i  in  1  wakeup 1 valid
- wk2_dest_i  in  6  wakeup tag, second single-cycle pipe
- wk2_valid_i  in  1  wakeup 2 valid
- issue_data_o  out  18  selected entry {rs2, rs1, rob}
- issue_valid_o  out  1  issue strobe
- occupancy_o  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Entry state: valid, rob[5:0], rs1[5:0], rs2[5:0], r1, r2. Entry 0 is oldest; valid entries are always contiguous from index 0.
- Reset: while core_reset_ni=0 at a clock edge, all valid bits and the count clear. After reset, issue_valid_o=0, occupancy_o=0, enq_ready_o=1. Reset overrides flush, enqueue and issue.
- Tag 0 is architecturally zero and always counts as ready, at enqueue and during wakeup.
- Wakeup match: an entry source matches when any wkN_valid_i=1 and wkN_dest_i equals its tag. The effective ready bit is (stored r) | match.
- The match is applied combinationally to selection, so a same-cycle wakeup makes the entry issuable that cycle (back-to-back dependent issue). The match is also stored at the clock edge.
- Select: lowest-index valid entry with both effective ready bits.
  - issue_valid_o=1 and issue_data_o = that entry, combinationally from registered state plus the wakeup inputs.
  - issue_valid_o=0 when core_flush_i=1. issue_data_o is don't-care when invalid.
- Issue latency: an entry enqueued at edge N is issuable no earlier than the cycle following edge N. There is no enqueue-to-issue bypass.
- Collapse: on issue from index k, entries k+1..count-1 shift down by one at the clock edge and keep their ready bits, including wakeups captured this cycle. Count decrements.
- Enqueue: when enq_valid_i & enq_ready_o, write at index count, or count-1 if an issue happens this cycle. Count increments (net 0 with a simultaneous issue).
  - Stored r1 = enq_rs1_rdy_i | (rs1==0) | wakeup match this cycle; r2 likewise.
- enq_ready_o = (count < DEPTH). It is registered-state based and does not credit a same-cycle issue. Enqueue with enq_ready_o=0 is ignored; the queue is not corrupted.
- Flush: at the edge where core_flush_i=1, all entries are invalidated and count becomes 0. A same-cycle enqueue is discarded.
- Occupancy arithmetic: count is $clog2(DEPTH)+1 bits and never exceeds DEPTH or underflows.
- At most one issue per cycle. An entry that issues is never re-issued.

Test Plan:
- Reset with enq_valid_i=1 held -> occupancy_o=0, issue_valid_o=0, enq_ready_o=1. The first post-reset enqueue {rob=3, rs1=0, rs2=0} issues one cycle later with issue_data_o=18'h00003.
- Enqueue A (rob 1, rs1=5 not ready), then B (rob 2, ready) -> B issues first (data {0,0,2}). Later wk1 (dest 5) -> A issues in the same cycle as the wakeup.
- Two ready entries rob 4 then rob 6 -> rob 4 issues first, rob 6 the next cycle. Occupancy goes 2→1→0.
- Fill to DEPTH=8 with sources 9 not ready -> enq_ready_o=0 and a 9th enqueue is ignored. wk2 dest 9 -> rob ids issue in enqueue order, one per cycle, and enq_ready_o returns to 1 after the first issue.
- Enqueue with rs1=7 coincident with wk0 dest 7 -> stored ready; issues next cycle without further wakeup.
- 5 entries queued, assert core_flush_i with a simultaneous enqueue -> issue_valid_o=0 in the flush cycle, occupancy_o=0 next cycle, and no stale entry issues afterwards.
